// File: rtl/tx_cmd_arbiter.sv
// tx_cmd_arbiter: round-robin sharing of one UART matrix transmitter between NREQ command sources.
// Define FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module tx_cmd_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int TMO  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] req_action,
    input  logic [NREQ-1:0]   req_row,
    input  logic [2*NREQ-1:0] req_col,
    input  logic [W*NREQ-1:0] req_d,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              err,
    output logic              arb_busy,
    output logic [W-1:0]      t_d,
    output logic              t_row,
    output logic [1:0]        t_col,
    output logic [3:0]        t_action,
    input  logic              t_busy
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TMO + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RISE, WAIT_FALL} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d, own_q, own_d, win;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d;
    logic            err_q, err_d, pend_q, pend_d, perr_q, perr_d, found, valid;
    logic [W-1:0]    td_q, td_d;
    logic            row_q, row_d;
    logic [1:0]      col_q, col_d;
    logic [3:0]      act_q, act_d, win_act;
    int              idx;

    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef FIXED_PRIO_EN
            idx = k;
`else
            idx = (int'(ptr_q) + k) % NREQ;
`endif
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx[IW-1:0];
            end
        end
    end

    assign win_act = req_action[4*win +: 4];
    assign valid   = (win_act >= 4'd1) && (win_act <= 4'd5);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        cnt_d   = cnt_q;
        td_d    = td_q;
        row_d   = row_q;
        col_d   = col_q;
        act_d   = '0;
        gnt_d   = '0;
        pend_d  = 1'b0;
        perr_d  = 1'b0;
        // a deferred completion (write or invalid action) reports one cycle late
        done_d  = pend_q ? NREQ'(1) << own_q : '0;
        err_d   = pend_q && perr_q;
        case (state_q)
            IDLE: begin
                // gnt_q blocks a re-grant while the requester is still dropping req
                if (found && !t_busy && gnt_q == '0) begin
                    gnt_d   = NREQ'(1) << win;
                    own_d   = win;
                    td_d    = req_d[W*win +: W];
                    row_d   = req_row[win];
                    col_d   = req_col[2*win +: 2];
`ifdef FIXED_PRIO_EN
                    ptr_d   = '0;
`else
                    ptr_d   = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
`endif
                    act_d   = valid ? win_act : 4'd0;
                    state_d = valid ? ISSUE : IDLE;
                    pend_d  = !valid;
                    perr_d  = !valid;
                end
            end
            ISSUE: begin
                pend_d  = (act_q == 4'd1);
                state_d = (act_q == 4'd1) ? IDLE : WAIT_RISE;
                cnt_d   = '0;
            end
            WAIT_RISE: begin
                if (t_busy) begin
                    state_d = WAIT_FALL;
                end else if (cnt_q == CW'(TMO - 1)) begin
                    done_d  = NREQ'(1) << own_q;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            WAIT_FALL: begin
                if (!t_busy) begin
                    done_d  = NREQ'(1) << own_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            own_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
            perr_q  <= 1'b0;
            td_q    <= '0;
            row_q   <= 1'b0;
            col_q   <= '0;
            act_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
            perr_q  <= perr_d;
            td_q    <= td_d;
            row_q   <= row_d;
            col_q   <= col_d;
            act_q   <= act_d;
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign err      = err_q;
    assign arb_busy = (state_q != IDLE);
    assign t_d      = td_q;
    assign t_row    = row_q;
    assign t_col    = col_q;
    assign t_action = act_q;
endmodule

// File: tb/tb_tx_cmd_arbiter.sv
// tb_tx_cmd_arbiter: scoreboard bench for tx_cmd_arbiter with a simple transmitter busy model.
module tb_tx_cmd_arbiter;
    localparam int NREQ  = 4;
    localparam int W     = 8;
    localparam int TMO   = 16;
    localparam int FRAME = 30;

    logic              clk, rst_n, t_busy, err, arb_busy, t_row;
    logic [NREQ-1:0]   req, gnt, done, req_row;
    logic [4*NREQ-1:0] req_action;
    logic [2*NREQ-1:0] req_col;
    logic [W*NREQ-1:0] req_d;
    logic [W-1:0]      t_d;
    logic [1:0]        t_col;
    logic [3:0]        t_action;
    logic [3:0]        act [NREQ];
    logic [1:0]        col [NREQ];
    logic [W-1:0]      dat [NREQ];
    logic              busy_en;
    int                busy_cnt;

    typedef struct {
        logic [NREQ-1:0] g;
        logic            e;
        int              lat;
    } exp_t;

    exp_t exp_q[$];
    int   gq[$];
    int   checks, errors, cyc, gcyc;

    tx_cmd_arbiter #(.NREQ(NREQ), .W(W), .TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_action(req_action), .req_row(req_row),
        .req_col(req_col), .req_d(req_d), .gnt(gnt), .done(done), .err(err),
        .arb_busy(arb_busy), .t_d(t_d), .t_row(t_row), .t_col(t_col),
        .t_action(t_action), .t_busy(t_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_action = '0;
        req_col    = '0;
        req_d      = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_action[4*i +: 4] = act[i];
            req_col[2*i +: 2]    = col[i];
            req_d[W*i +: W]      = dat[i];
        end
    end

    // transmitter: send actions raise busy the edge after ISSUE for FRAME cycles
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_cnt <= 0;
        else if (busy_en && t_action >= 4'd2 && t_action <= 4'd5) busy_cnt <= FRAME;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign t_busy = (busy_cnt != 0);

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (done !== '0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: got done=%b err=%b, expected none", done, err);
            end else begin
                e = exp_q.pop_front();
                if (done !== e.g || err !== e.e || cyc - gcyc != e.lat) begin
                    errors++;
                    $display("FAIL done: got done=%b err=%b lat=%0d, expected done=%b err=%b lat=%0d",
                             done, err, cyc - gcyc, e.g, e.e, e.lat);
                end
            end
        end
        if (gnt !== '0) begin
            checks++;
            if (exp_q.size() == 0 || gnt !== exp_q[0].g) begin
                errors++;
                $display("FAIL gnt: got %b, expected %b", gnt, exp_q.size() ? exp_q[0].g : 4'b0);
            end
            gcyc = cyc;
            gq.push_back(cyc);
        end
    end

    task automatic tick();
        @(negedge clk);
        req = req & ~gnt;
    endtask

    task automatic drain(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < n && !ok; i++) begin
            tick();
            ok = (exp_q.size() == 0);
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, done, err, arb_busy, t_d, t_row, t_col, t_action} !== '0) begin
            errors++;
            $display("FAIL reset: got gnt=%b done=%b err=%b busy=%b d=%h row=%b col=%h act=%h, expected all 0",
                     gnt, done, err, arb_busy, t_d, t_row, t_col, t_action);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write();
        bit ok;
        act[0] = 4'd1; col[0] = 2'd2; dat[0] = 8'hA5; req_row = 4'b0001;
        exp_q.push_back('{4'b0001, 1'b0, 2});
        req = 4'b0001;
        tick();
        checks++;
        if (t_action !== 4'd1 || t_d !== 8'hA5 || t_row !== 1'b1 || t_col !== 2'd2) begin
            errors++;
            $display("FAIL write_fields: got act=%h d=%h row=%b col=%h, expected 1 a5 1 2", t_action, t_d, t_row, t_col);
        end
        tick();
        checks++;
        if (t_action !== 4'd0 || t_d !== 8'hA5) begin
            errors++;
            $display("FAIL write_issue_len: got act=%h d=%h, expected 0 a5", t_action, t_d);
        end
        drain(20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL write_timeout: got %0d pending, expected 0", exp_q.size()); end
    endtask

    task automatic test_rr_ptr();
        bit ok;
        act[0] = 4'd1; act[2] = 4'd1;
`ifdef FIXED_PRIO_EN
        exp_q.push_back('{4'b0001, 1'b0, 2});
        exp_q.push_back('{4'b0100, 1'b0, 2});
`else
        exp_q.push_back('{4'b0100, 1'b0, 2});
        exp_q.push_back('{4'b0001, 1'b0, 2});
`endif
        req = 4'b0101;
        drain(30, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rr_timeout: got %0d pending, expected 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        gq.delete();
        for (int i = 0; i < NREQ; i++) begin
            act[i] = 4'd1;
            exp_q.push_back('{4'(1 << i), 1'b0, 2});
        end
        req = 4'b1111;
        drain(40, ok);
        checks++;
        if (!ok || gq.size() != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d grants, expected 4", gq.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (gq[i] - gq[i-1] != 2) begin
                    errors++;
                    $display("FAIL b2b_gap: got %0d cycles, expected 2", gq[i] - gq[i-1]);
                end
            end
        end
    endtask

    task automatic test_send();
        bit ok;
        act[0] = 4'd2; act[1] = 4'd1;
        exp_q.push_back('{4'b0001, 1'b0, FRAME + 2});
        exp_q.push_back('{4'b0010, 1'b0, 2});
        req = 4'b0001;
        tick();
        req = req | 4'b0010;
        repeat (10) tick();
        checks++;
        if (arb_busy !== 1'b1 || t_busy !== 1'b1 || req[1] !== 1'b1) begin
            errors++;
            $display("FAIL send_frame: got arb_busy=%b t_busy=%b req1=%b, expected 1 1 1", arb_busy, t_busy, req[1]);
        end
        drain(100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL send_timeout: got %0d pending, expected 0", exp_q.size()); end
    endtask

    task automatic test_invalid();
        bit ok;
        act[2] = 4'd7;
        exp_q.push_back('{4'b0100, 1'b1, 1});
        req = 4'b0100;
        tick();
        checks++;
        if (gnt !== 4'b0100 || t_action !== 4'd0 || arb_busy !== 1'b0) begin
            errors++;
            $display("FAIL invalid_gnt: got gnt=%b act=%h busy=%b, expected 0100 0 0", gnt, t_action, arb_busy);
        end
        tick();
        checks++;
        if (done !== 4'b0100 || err !== 1'b1 || t_action !== 4'd0) begin
            errors++;
            $display("FAIL invalid_done: got done=%b err=%b act=%h, expected 0100 1 0", done, err, t_action);
        end
        drain(10, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL invalid_timeout: got %0d pending, expected 0", exp_q.size()); end
    endtask

    task automatic test_timeout();
        bit ok, prev;
        busy_en = 1'b0;
        act[0] = 4'd3;
        exp_q.push_back('{4'b0001, 1'b1, TMO + 1});
        req = 4'b0001;
        prev = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            tick();
            ok = (done !== '0);
            if (!ok) prev = arb_busy;
        end
        checks++;
        if (!ok || arb_busy !== 1'b0 || prev !== 1'b1) begin
            errors++;
            $display("FAIL tmo_busy: got seen=%b busy=%b prev=%b, expected 1 0 1", ok, arb_busy, prev);
        end
        busy_en = 1'b1;
        drain(10, ok);
    endtask

    task automatic test_reset_mid();
        bit ok;
        act[0] = 4'd2; dat[0] = 8'h3C;
        exp_q.push_back('{4'b0001, 1'b0, FRAME + 2});
        req = 4'b0001;
        repeat (12) tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, done, err, arb_busy, t_d, t_row, t_col, t_action} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got gnt=%b done=%b err=%b busy=%b d=%h act=%h, expected all 0",
                     gnt, done, err, arb_busy, t_d, t_action);
        end
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        act[1] = 4'd1; dat[1] = 8'h5A;
        exp_q.push_back('{4'b0010, 1'b0, 2});
        req = 4'b0010;
        tick();
        checks++;
        if (t_d !== 8'h5A || t_action !== 4'd1) begin
            errors++;
            $display("FAIL reset_regrant: got d=%h act=%h, expected 5a 1", t_d, t_action);
        end
        drain(20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL regrant_timeout: got %0d pending, expected 0", exp_q.size()); end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; gcyc = 0;
        req = '0; req_row = '0; busy_en = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            act[i] = '0; col[i] = '0; dat[i] = '0;
        end
        test_reset();
        test_write();
        test_rr_ptr();
        test_back_to_back();
        test_send();
        test_invalid();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tx_cmd_arbiter.md
Name: tx_cmd_arbiter

Overview:
Shares one UART matrix transmitter between NREQ requesters. Accepts per-requester commands (action/row/col/data) and grants one at a time, round-robin. Drives the transmitter's command port for exactly one cycle, then tracks its busy flag until the operation completes. Sits between the host-side command sources and the transmitter.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 8, data width; must match transmitter W
TMO, 16, cycles to wait for t_busy rise after a send command before flagging an error

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  NREQ  per-requester request, level; held until gnt
req_action  input  4*NREQ  action of requester i at bits [4i+3:4i]
req_row  input  NREQ  row of requester i at bit i
req_col  input  2*NREQ  col of requester i at bits [2i+1:2i]
req_d  input  W*NREQ  data of requester i at bits [W*i+W-1:W*i]
gnt  output  NREQ  one-hot, 1-cycle pulse: command of requester i latched
done  output  NREQ  one-hot, 1-cycle pulse: command of requester i completed
err  output  1  1-cycle pulse with done: invalid action or busy timeout
arb_busy  output  1  high whenever state != IDLE
t_d  output  W  to transmitter d
t_row  output  1  to transmitter row
t_col  output  2  to transmitter col
t_action  output  4  to transmitter action; nonzero only in ISSUE
t_busy  input  1  from transmitter busy

Behaviour:
- All outputs registered. Reset (rst_n=0, any time, async): state=IDLE, gnt=0, done=0, err=0, arb_busy=0, t_d=0, t_row=0, t_col=0, t_action=0, rr pointer=0. An in-flight command is dropped, with no done.
- States: IDLE, ISSUE, WAIT_RISE, WAIT_FALL.
- IDLE: if req!=0 and t_busy=0, select a winner by round-robin starting at index ptr. At the edge: latch the winner's fields into t_d/t_row/t_col; set gnt[winner]=1 for one cycle; ptr=winner+1 mod NREQ.
  - Action 1..5: t_action=action, go ISSUE.
  - Action 0 or 6..15: t_action stays 0; next cycle done[winner]=1 and err=1; stay IDLE.
- If t_busy=1 in IDLE, no grant is issued.
- ISSUE (exactly 1 cycle, t_action valid): at the edge, t_action=0.
  - Action 1 (write): done pulse next cycle, go IDLE.
  - Actions 2..5: go WAIT_RISE, timeout counter=0.
- WAIT_RISE: if t_busy=1, go WAIT_FALL. Otherwise increment the counter; when it reaches TMO-1, pulse done and err, go IDLE.
- WAIT_FALL: on t_busy=0, pulse done[owner] with err=0, go IDLE. No timeout applies (frame length is unbounded by design).
- Throughput:
  - Write: gnt at edge N, done at edge N+2, next gnt possible at edge N+2.
  - Send: done is asserted the cycle after t_busy falls.
- req for the granted requester is sampled only in IDLE. A requester that deasserts req before gnt simply loses its slot.
- gnt and done are never both asserted to the same requester in the same cycle, except for invalid actions, which pulse done the cycle after gnt.
- The owner index is held from grant until done. The t_d/t_row/t_col outputs hold their values until the next grant.

Optional Feature:
FIXED_PRIO_EN
- Defined: fixed priority; the lowest requesting index always wins, and ptr is unused (held 0).
- Undefined: round-robin as above.
- All other timing is identical in both cases.

Test Plan:
1. req=4'b0001, action=1, row=1, col=2, d=8'hA5 -> gnt=0001 one cycle; t_action=1 for one cycle; done=0001 two edges after gnt; transmitter t_cell at (1,2) reads A5.
2. req=4'b1111, all action=1 from reset -> grants in order 0001, 0010, 0100, 1000, each 2 cycles apart. With FIXED_PRIO_EN and req held: always 0001.
3. req0 action=2, transmitter DIV=3, PAR=0 -> t_busy rises the edge after ISSUE; done=0001 the cycle after t_busy falls (30 cycles frame); no grant during the frame despite req1=1.
4. req2 action=7 -> gnt=0100, then done=0100 with err=1 next cycle; t_action stays 0.
5. req0 action=3, t_busy tied 0 -> done=0001 with err=1 exactly TMO cycles after WAIT_RISE entry; arb_busy falls with it.
6. rst_n pulsed low during WAIT_FALL -> all outputs 0 immediately, no done; new req is granted normally after release.
